// File: rtl/axis_pixels_pack_pkg.sv
// Shared definitions for the pixel-stream front end: sizes, header layout,
// FSM states and the per-beat shift helper.
package axis_pixels_pkg;

  localparam int S_WORDS     = 8;
  localparam int WORD_WIDTH  = 8;
  localparam int M_WORDS_MAX = 24;
  localparam int KH_MAX      = 3;
  localparam int SH_MAX      = 2;
  localparam int ONES_MAX    = 16;

  localparam int S_DATA_W = S_WORDS * WORD_WIDTH;
  localparam int M_DATA_W = M_WORDS_MAX * WORD_WIDTH;

  // Packer capacity: one full output beat plus one input beat minus a word
  localparam int CAP    = M_WORDS_MAX + S_WORDS - 1;
  localparam int FILL_W = $clog2(CAP + 1);

  // Header field widths (LSB first: flags, kh2, sh_1, words, ones_1)
  localparam int BITS_KH2   = $clog2((KH_MAX - 1) / 2 + 1);
  localparam int BITS_SH    = $clog2(SH_MAX);
  localparam int BITS_WORDS = $clog2(M_WORDS_MAX + 1);
  localparam int BITS_ONES  = $clog2(ONES_MAX);
  localparam int SHIFT_W    = $clog2(KH_MAX);

  localparam int OFF_KH2   = 3;
  localparam int OFF_SH    = OFF_KH2 + BITS_KH2;
  localparam int OFF_WORDS = OFF_SH + BITS_SH;
  localparam int OFF_ONES  = OFF_WORDS + BITS_WORDS;
  localparam int HDR_W     = OFF_ONES + BITS_ONES;

  typedef struct packed {
    logic [BITS_ONES-1:0]  ones_1;
    logic [BITS_WORDS-1:0] words;
    logic [BITS_SH-1:0]    sh_1;
    logic [BITS_KH2-1:0]   kh2;
    logic                  is_lrelu;
    logic                  is_max;
    logic                  is_not_max;
  } hdr_t;

  typedef enum logic [1:0] {S_SET, S_ONES, S_PASS, S_DRAIN} state_t;

  function automatic logic hdr_ok(hdr_t h);
    return (h.words != '0) && (int'(h.words) <= M_WORDS_MAX) &&
           (2 * int'(h.kh2) + 1 <= KH_MAX) && (int'(h.sh_1) < SH_MAX);
  endfunction

  // Last beat of a stride group uses floor(k/s)-1, the others ceil(k/s)-1.
  // Saturates at 0 so a 1-row kernel with stride 2 does not wrap.
  function automatic logic [SHIFT_W-1:0] shift_amt(logic [BITS_KH2-1:0] kh2,
                                                   logic [BITS_SH-1:0] sh_1,
                                                   logic is_last);
    int k;
    int s;
    int q;
    k = 2 * int'(kh2) + 1;
    s = int'(sh_1) + 1;
    q = is_last ? (k / s) : ((k + s - 1) / s);
    q = (q > 0) ? q - 1 : 0;
    return SHIFT_W'(q);
  endfunction

endpackage

// File: rtl/axis_pixels_pack_if.sv
// Input and output stream bundle of the pixel packer.
interface axis_pixels_pack_if;
  import axis_pixels_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic [S_DATA_W-1:0] s_data;
  logic [S_WORDS-1:0]  s_keep;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic [M_DATA_W-1:0] m_data;
  logic                m_ones;
  logic [SHIFT_W-1:0]  m_shift;
  logic [2:0]          m_user;
  logic                err;

  modport master (
    output s_valid, s_last, s_data, s_keep, m_ready,
    input  s_ready, m_valid, m_last, m_data, m_ones, m_shift, m_user, err
  );

  modport slave (
    input  s_valid, s_last, s_data, s_keep, m_ready,
    output s_ready, m_valid, m_last, m_data, m_ones, m_shift, m_user, err
  );
endinterface

// File: rtl/axis_pixels_pack_packer.sv
// Variable-width word packer: appends kept input words, emits `words`-wide
// beats, zero-pads the final beat of an image.
module axis_word_packer
  import axis_pixels_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [BITS_WORDS-1:0] words,
  input  logic                  push,
  input  logic [S_DATA_W-1:0]   push_data,
  input  logic [S_WORDS-1:0]    push_keep,
  input  logic                  push_last,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [M_DATA_W-1:0]   out_data
);

  logic [WORD_WIDTH-1:0] buf_reg  [CAP];
  logic [WORD_WIDTH-1:0] buf_next [CAP];
  logic [FILL_W-1:0]     fill_reg, fill_next;
  logic [FILL_W-1:0]     base;
  logic [FILL_W-1:0]     keep_cnt;
  logic [FILL_W-1:0]     words_f;
  logic                  last_in_reg, last_in_next;

  assign words_f = FILL_W'(words);

  // Fill level once this cycle's pop is applied; new words land here
  assign base = !pop ? fill_reg : (fill_reg > words_f) ? fill_reg - words_f : '0;

  // No more input after the last beat until the image has fully drained
  assign push_ready = !last_in_reg && (int'(base) + S_WORDS <= CAP);
  assign out_valid  = (fill_reg >= words_f) || (last_in_reg && fill_reg != '0);
  assign out_last   = last_in_reg && (fill_reg <= words_f);

  // Count of kept words (keep is a contiguous prefix)
  always_comb begin
    keep_cnt = '0;
    for (int j = 0; j < S_WORDS; j++) begin
      keep_cnt = keep_cnt + FILL_W'(push_keep[j]);
    end
  end

  // Shift down by `words` on pop, then append the kept words at base
  always_comb begin
    for (int i = 0; i < CAP; i++) begin
      buf_next[i] = buf_reg[i];
    end
    if (pop) begin
      for (int i = 0; i < CAP; i++) begin
        if (i + int'(words) < CAP) buf_next[i] = buf_reg[i + int'(words)];
        else                       buf_next[i] = '0;
      end
    end
    if (push) begin
      for (int j = 0; j < S_WORDS; j++) begin
        if (push_keep[j] && (int'(base) + j < CAP)) begin
          buf_next[int'(base) + j] = push_data[j*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  // Fill and end-of-image tracking
  always_comb begin
    fill_next    = base + (push ? keep_cnt : '0);
    last_in_next = last_in_reg;
    if (pop && out_last)   last_in_next = 1'b0;
    if (push && push_last) last_in_next = 1'b1;
  end

  // Control registers, cleared by reset so stale buffer contents are masked
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fill_reg    <= '0;
      last_in_reg <= 1'b0;
    end else begin
      fill_reg    <= fill_next;
      last_in_reg <= last_in_next;
    end
  end

  // Word storage; contents beyond fill are never observed
  always_ff @(posedge aclk) begin
    buf_reg <= buf_next;
  end

  // Present the low `words` words, zeroing anything past fill or past words
  generate
    for (genvar gi = 0; gi < M_WORDS_MAX; gi++) begin : g_out
      assign out_data[gi*WORD_WIDTH +: WORD_WIDTH] =
        (gi < int'(fill_reg) && gi < int'(words)) ? buf_reg[gi] : '0;
    end
  endgenerate

endmodule

// File: rtl/axis_pixels_pack.sv
// Pixel-stream front end: samples the header beat, emits the ones beats,
// then streams repacked payload beats with shift metadata.
module axis_pixels_pack
  import axis_pixels_pkg::*;
(
  input  logic              aclk,
  input  logic              areset,
  axis_pixels_pack_if.slave bus
);

  state_t                 state_reg, state_next;
  hdr_t                   cfg_reg, cfg_next;
  hdr_t                   hdr_in;
  logic                   err_reg, err_next;
  logic [BITS_ONES-1:0]   ones_cnt_reg, ones_cnt_next;
  logic [BITS_SH-1:0]     count_sh_reg, count_sh_next;
  logic                   up_reg;
  logic                   in_stream, s_beat;
  logic                   pk_ready, pk_push, pk_pop, pk_valid, pk_last;
  logic [M_DATA_W-1:0]    pk_data;

  assign hdr_in    = hdr_t'(bus.s_data[HDR_W-1:0]);
  assign in_stream = (state_reg == S_ONES) || (state_reg == S_PASS);

  // up_reg keeps s_ready low while reset is held and for the release cycle
  assign bus.s_ready = up_reg & (in_stream ? pk_ready : 1'b1);
  assign s_beat      = bus.s_valid & bus.s_ready;
  assign pk_push     = in_stream & s_beat;
  assign pk_pop      = (state_reg == S_PASS) & pk_valid & bus.m_ready;
  assign bus.m_user  = {cfg_reg.is_lrelu, cfg_reg.is_max, cfg_reg.is_not_max};
  assign bus.err     = err_reg;

  axis_word_packer u_packer (
    .aclk       (aclk),
    .areset     (areset),
    .words      (cfg_reg.words),
    .push       (pk_push),
    .push_data  (bus.s_data),
    .push_keep  (bus.s_keep),
    .push_last  (bus.s_last),
    .push_ready (pk_ready),
    .pop        (pk_pop),
    .out_valid  (pk_valid),
    .out_last   (pk_last),
    .out_data   (pk_data)
  );

  // Next-state and output decode
  always_comb begin
    state_next    = state_reg;
    cfg_next      = cfg_reg;
    err_next      = err_reg;
    ones_cnt_next = ones_cnt_reg;
    count_sh_next = count_sh_reg;
    bus.m_valid   = 1'b0;
    bus.m_last    = 1'b0;
    bus.m_ones    = 1'b0;
    bus.m_data    = '0;
    bus.m_shift   = '0;
    case (state_reg)
      S_SET: begin
        if (s_beat) begin
          cfg_next      = hdr_in;
          count_sh_next = '0;
          ones_cnt_next = '0;
          err_next      = !hdr_ok(hdr_in);
          if (bus.s_last)          state_next = S_SET;
          else if (hdr_ok(hdr_in)) state_next = S_ONES;
          else                     state_next = S_DRAIN;
        end
      end
      S_ONES: begin
        bus.m_valid = 1'b1;
        bus.m_ones  = 1'b1;
        bus.m_data  = M_DATA_W'(1);
        if (bus.m_ready) begin
          ones_cnt_next = ones_cnt_reg + BITS_ONES'(1);
          if (ones_cnt_reg == cfg_reg.ones_1) state_next = S_PASS;
        end
      end
      S_PASS: begin
        bus.m_valid = pk_valid;
        bus.m_last  = pk_last;
        bus.m_data  = pk_data;
        bus.m_shift = shift_amt(cfg_reg.kh2, cfg_reg.sh_1, count_sh_reg == cfg_reg.sh_1);
        if (pk_pop) begin
          count_sh_next = (count_sh_reg == cfg_reg.sh_1) ? '0 : count_sh_reg + BITS_SH'(1);
          if (pk_last) state_next = S_SET;
        end
      end
      S_DRAIN: begin
        if (s_beat && bus.s_last) state_next = S_SET;
      end
      default: state_next = S_SET;
    endcase
  end

  // State, config and counter registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg    <= S_SET;
      cfg_reg      <= '0;
      err_reg      <= 1'b0;
      ones_cnt_reg <= '0;
      count_sh_reg <= '0;
      up_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cfg_reg      <= cfg_next;
      err_reg      <= err_next;
      ones_cnt_reg <= ones_cnt_next;
      count_sh_reg <= count_sh_next;
      up_reg       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pixels_pack.sv
// Directed bench for axis_pixels_pack with a queue-based scoreboard.
module tb_axis_pixels_pack;
  import axis_pixels_pkg::*;

  typedef logic [M_DATA_W-1:0] w_t;

  typedef struct packed {
    logic [M_DATA_W-1:0] data;
    logic                last;
    logic                ones;
    logic [SHIFT_W-1:0]  shift;
    logic [2:0]          user;
  } beat_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  axis_pixels_pack_if bus ();

  axis_pixels_pack dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  beat_t exp_q[$];
  int    n_cmp     = 0;
  int    n_bad     = 0;
  int    ready_pct = 100;
  int    stall_cnt = 0;

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_shift(int kh2, int sh_1, int cnt);
    int k;
    int s;
    int q;
    k = 2 * kh2 + 1;
    s = sh_1 + 1;
    q = (cnt == sh_1) ? k / s : (k + s - 1) / s;
    return (q > 0) ? q - 1 : 0;
  endfunction

  function automatic logic [S_DATA_W-1:0] make_hdr(int words, int kh2, int sh_1, int ones_1,
                                                   logic [2:0] user);
    logic [S_DATA_W-1:0] h;
    h        = '0;
    h[2:0]   = user;
    h[3]     = kh2[0];
    h[4]     = sh_1[0];
    h[9:5]   = words[4:0];
    h[13:10] = ones_1[3:0];
    return h;
  endfunction

  // Output consumer with random backpressure
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(negedge aclk);
      bus.m_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Monitor: every accepted output beat is popped and compared
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      #2;
      if (bus.m_valid && bus.m_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0)
        else begin
          n_bad++;
          $error("FAIL unexpected_beat: observed m_data %0h expected no beat", bus.m_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data",  bus.m_data,          e.data);
          check("m_last",  w_t'(bus.m_last),    w_t'(e.last));
          check("m_ones",  w_t'(bus.m_ones),    w_t'(e.ones));
          check("m_shift", w_t'(bus.m_shift),   w_t'(e.shift));
          check("m_user",  w_t'(bus.m_user),    w_t'(e.user));
        end
      end
    end
  end

  task automatic send(input logic [S_DATA_W-1:0] d, input logic [S_WORDS-1:0] k,
                      input logic l, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
    @(negedge aclk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    t = 0;
    #1;
    while (!bus.s_ready && t < 2000) begin
      stall_cnt++;
      @(negedge aclk);
      #1;
      t++;
    end
    if (t >= 2000) check("s_ready_timeout", w_t'(bus.s_ready), w_t'(1));
    @(posedge aclk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  // Header plus nbeats payload beats; last beat keeps last_cnt words
  task automatic run_image(input int words, input int kh2, input int sh_1, input int ones_1,
                           input logic [2:0] user, input int nbeats, input int last_cnt,
                           input bit gaps, input bit expect_out);
    logic [7:0]          pay[$];
    logic [S_DATA_W-1:0] d;
    logic [S_WORDS-1:0]  k;
    beat_t               e;
    int                  n;
    int                  nout;
    int                  idx;
    n = (nbeats == 0) ? 0 : (nbeats - 1) * S_WORDS + last_cnt;
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    if (expect_out && nbeats > 0) begin
      for (int b = 0; b <= ones_1; b++) begin
        e = '{data: w_t'(1), last: 1'b0, ones: 1'b1, shift: '0, user: user};
        exp_q.push_back(e);
      end
      nout = (n + words - 1) / words;
      for (int b = 0; b < nout; b++) begin
        e.data = '0;
        for (int i = 0; i < words; i++) begin
          idx = b * words + i;
          if (idx < n) e.data[i*8 +: 8] = pay[idx];
        end
        e.last  = (b == nout - 1);
        e.ones  = 1'b0;
        e.shift = SHIFT_W'(exp_shift(kh2, sh_1, b % (sh_1 + 1)));
        e.user  = user;
        exp_q.push_back(e);
      end
    end
    send(make_hdr(words, kh2, sh_1, ones_1, user), '1, nbeats == 0, gaps);
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      k = (b == nbeats - 1) ? S_WORDS'((1 << last_cnt) - 1) : '1;
      for (int w = 0; w < S_WORDS; w++) begin
        idx = b * S_WORDS + w;
        d[w*8 +: 8] = (idx < n) ? pay[idx] : 8'hA5;
      end
      send(d, k, b == nbeats - 1, gaps);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    check(tag, w_t'(exp_q.size()), w_t'(0));
    repeat (6) @(negedge aclk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.s_keep  = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst_s_ready", w_t'(bus.s_ready), w_t'(0));
    check("rst_m_valid", w_t'(bus.m_valid), w_t'(0));
    check("rst_m_last",  w_t'(bus.m_last),  w_t'(0));
    check("rst_m_ones",  w_t'(bus.m_ones),  w_t'(0));
    check("rst_err",     w_t'(bus.err),     w_t'(0));
    check("rst_m_user",  w_t'(bus.m_user),  w_t'(0));
    check("rst_m_data",  bus.m_data,        w_t'(0));
    check("rst_m_shift", w_t'(bus.m_shift), w_t'(0));
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    #1;
    check("post_rst_s_ready", w_t'(bus.s_ready), w_t'(1));

    // Happy path: words=10, k=3, s=1, three ones beats
    run_image(10, 1, 0, 2, 3'b101, 4, 8, 1'b0, 1'b1);
    wait_drain("happy_drain");
    check("happy_user", w_t'(bus.m_user), w_t'(3'b101));
    check("happy_err",  w_t'(bus.err),    w_t'(0));

    // Stride wrap: k=3, s=2 -> shift 1,0,1,0...
    run_image(8, 1, 1, 1, 3'b010, 6, 8, 1'b0, 1'b1);
    wait_drain("stride_drain");

    // Backpressure, narrower output than input then widest output
    ready_pct = 30;
    stall_cnt = 0;
    run_image(5, 1, 1, 3, 3'b001, 10, 6, 1'b1, 1'b1);
    wait_drain("bp5_drain");
    check("bp5_stalled", w_t'(stall_cnt > 0), w_t'(1));
    run_image(24, 0, 0, 0, 3'b100, 9, 5, 1'b1, 1'b1);
    wait_drain("bp24_drain");
    ready_pct = 100;

    // Partial keep on the last beat
    run_image(8, 1, 0, 0, 3'b000, 3, 3, 1'b0, 1'b1);
    wait_drain("partial_drain");

    // Bad header (words=0) is dropped, then a good image clears err
    run_image(0, 1, 0, 1, 3'b111, 4, 8, 1'b0, 1'b0);
    wait_drain("bad0_drain");
    check("bad0_err", w_t'(bus.err), w_t'(1));
    run_image(12, 1, 1, 0, 3'b011, 5, 4, 1'b0, 1'b1);
    wait_drain("good_after_bad_drain");
    check("good_err", w_t'(bus.err), w_t'(0));
    run_image(25, 0, 0, 0, 3'b000, 2, 8, 1'b0, 1'b0);
    wait_drain("bad25_drain");
    check("bad25_err", w_t'(bus.err), w_t'(1));
    // Header-only image: valid, no output, err cleared
    run_image(8, 0, 0, 0, 3'b110, 0, 0, 1'b0, 1'b1);
    wait_drain("empty_drain");
    check("empty_err", w_t'(bus.err), w_t'(0));

    // Mid-image reset with words parked in the buffer
    ready_pct = 0;
    @(negedge aclk);
    send(make_hdr(10, 1, 0, 0, 3'b101), '1, 1'b0, 1'b0);
    send({8{8'h3C}}, '1, 1'b0, 1'b0);
    send({8{8'h5A}}, '1, 1'b0, 1'b0);
    @(negedge aclk);
    #1;
    check("pre_rst_m_valid", w_t'(bus.m_valid), w_t'(1));
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("mid_rst_s_ready", w_t'(bus.s_ready), w_t'(0));
    check("mid_rst_m_valid", w_t'(bus.m_valid), w_t'(0));
    check("mid_rst_m_ones",  w_t'(bus.m_ones),  w_t'(0));
    check("mid_rst_m_data",  bus.m_data,        w_t'(0));
    check("mid_rst_m_user",  w_t'(bus.m_user),  w_t'(0));
    exp_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    ready_pct = 100;
    @(negedge aclk);
    #1;
    check("mid_rst_release_s_ready", w_t'(bus.s_ready), w_t'(1));
    run_image(6, 1, 0, 1, 3'b010, 3, 7, 1'b0, 1'b1);
    wait_drain("after_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
